// File: rtl/bit_stream_gen.sv
// Serial bit-stream generator: shifts a captured 16-bit pattern out LSB first,
// one bit every TICK_DIV clocks, with debounced load and pause/resume buttons.
module bit_stream_gen #(
  parameter int unsigned TICK_DIV   = 25000000,
  parameter int unsigned DEB_CYCLES = 250000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] pattern_in,
  input  logic        load_btn,
  input  logic        pause_btn,
  output logic        bit_out,
  output logic        bit_valid,
  output logic        paused,
  output logic [3:0]  pos
);

  localparam logic [31:0] TickLast = 32'(TICK_DIV - 1);
  localparam logic [23:0] DebLast  = 24'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StPaused = 2'd2
  } state_e;

  // Button path, index 0 = load, index 1 = pause.
  logic [1:0]  sync1_q, sync2_q;
  logic [1:0]  deb_q, deb_prev_q;
  logic [23:0] deb_cnt_q [2];
  logic        load_evt, pause_evt;

  state_e      state_q, state_d;
  logic [31:0] tick_q, tick_d;
  logic [3:0]  pos_q, pos_d, pos_inc;
  logic [15:0] shadow_q, shadow_d;
  logic        bit_q, bit_d;
  logic        valid_q, valid_d;
  logic        paused_q, paused_d;

  // Synchronize raw buttons, then debounce: the accepted level flips only after
  // DEB_CYCLES consecutive samples disagree with it; any agreeing sample restarts.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      for (int i = 0; i < 2; i++) begin
        deb_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q    <= {pause_btn, load_btn};
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] != deb_q[i]) begin
          if (deb_cnt_q[i] == DebLast) begin
            deb_q[i]     <= sync2_q[i];
            deb_cnt_q[i] <= '0;
          end else begin
            deb_cnt_q[i] <= deb_cnt_q[i] + 24'd1;
          end
        end else begin
          deb_cnt_q[i] <= '0;
        end
      end
    end
  end

  // Press events on debounced rising edges only.
  assign load_evt  = deb_q[0] & ~deb_prev_q[0];
  assign pause_evt = deb_q[1] & ~deb_prev_q[1];

  assign pos_inc = pos_q + 4'd1;

  // Next-state and datapath updates; load overrides everything, including pause.
  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    pos_d    = pos_q;
    shadow_d = shadow_q;
    bit_d    = bit_q;
    valid_d  = 1'b0;
    if (load_evt) begin
      state_d  = StRun;
      shadow_d = pattern_in;
      pos_d    = 4'd0;
      tick_d   = '0;
      bit_d    = pattern_in[0];
      valid_d  = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          tick_d = '0;
          bit_d  = 1'b0;
        end
        StRun: begin
          if (pause_evt) begin
            // Tick is left untouched so resume continues the partial period.
            state_d = StPaused;
          end else if (tick_q == TickLast) begin
            tick_d  = '0;
            pos_d   = pos_inc;
            bit_d   = shadow_q[pos_inc];
            valid_d = 1'b1;
          end else begin
            tick_d = tick_q + 32'd1;
          end
        end
        StPaused: begin
          if (pause_evt) begin
            state_d = StRun;
          end
        end
        default: state_d = StIdle;
      endcase
    end
    paused_d = (state_d == StPaused);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      tick_q   <= '0;
      pos_q    <= '0;
      shadow_q <= '0;
      bit_q    <= 1'b0;
      valid_q  <= 1'b0;
      paused_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      pos_q    <= pos_d;
      shadow_q <= shadow_d;
      bit_q    <= bit_d;
      valid_q  <= valid_d;
      paused_q <= paused_d;
    end
  end

  assign bit_out   = bit_q;
  assign bit_valid = valid_q;
  assign paused    = paused_q;
  assign pos       = pos_q;

endmodule

// File: tb/tb_bit_stream_gen.sv
// Scoreboard bench for bit_stream_gen with TICK_DIV=4, DEB_CYCLES=3.
module tb_bit_stream_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pattern_in;
  logic        load_btn, pause_btn;
  logic        bit_out, bit_valid, paused;
  logic [3:0]  pos;
  logic        toggle_en;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic       b;
    logic [3:0] p;
  } exp_t;

  exp_t q[$];
  exp_t e;
  logic prev_valid = 1'b0;

  bit_stream_gen #(
    .TICK_DIV  (4),
    .DEB_CYCLES(3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pattern_in(pattern_in),
    .load_btn  (load_btn),
    .pause_btn (pause_btn),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .paused    (paused),
    .pos       (pos)
  );

  always #5 clk = ~clk;

  // Monitor: every bit_valid pulse must match the next expected entry.
  always @(negedge clk) begin
    if (bit_valid) begin
      checks++;
      if (prev_valid) begin
        errors++;
        $display("FAIL valid_consecutive: bit_valid high on two cycles, required single pulses");
      end
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: got bit=%0d pos=%0d, required no bit_valid",
                 bit_out, pos);
      end else begin
        e = q.pop_front();
        if (bit_out !== e.b || pos !== e.p) begin
          errors++;
          $display("FAIL stream_bit: got bit=%0d pos=%0d, required bit=%0d pos=%0d",
                   bit_out, pos, e.b, e.p);
        end
      end
    end
    prev_valid = bit_valid;
  end

  // Pattern toggler for checking that switches only matter at load time.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (toggle_en) pattern_in = ~pattern_in;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push_seq(input logic [15:0] pat, input int start, input int n);
    int p;
    for (int i = 0; i < n; i++) begin
      p = (start + i) % 16;
      q.push_back({pat[p], 4'(p)});
    end
  endtask

  // Counts falling edges until bit_valid (optionally at a given pos); -1 on timeout.
  task automatic wait_valid(input int maxc, input bit use_pos, input logic [3:0] want,
                            output int n);
    n = -1;
    for (int i = 1; i <= maxc; i++) begin
      @(negedge clk);
      if (bit_valid && (!use_pos || pos == want)) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_paused(input int maxc, output int n);
    n = -1;
    for (int i = 1; i <= maxc; i++) begin
      @(negedge clk);
      if (paused) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic held_ok;
    logic [15:0] pat1, pat2;
    logic        hold_bit;
    logic [3:0]  hold_pos;

    pat1 = 16'hA5C3;
    pat2 = 16'h3C5A;
    reset = 1'b1;
    load_btn = 1'b0;
    pause_btn = 1'b0;
    pattern_in = 16'h0000;
    toggle_en = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_bit_out", 32'(bit_out), 0);
    check("reset_bit_valid", 32'(bit_valid), 0);
    check("reset_paused", 32'(paused), 0);
    check("reset_pos", 32'(pos), 0);
    reset = 1'b0;

    // Pause is ignored in IDLE.
    pause_btn = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_pause_ignored", 32'(paused), 0);
    check("idle_bit_out", 32'(bit_out), 0);
    pause_btn = 1'b0;
    repeat (8) @(negedge clk);

    // Bouncing load press, then a stable hold.
    pattern_in = pat1;
    push_seq(pat1, 0, 23);
    load_btn = 1'b1; @(negedge clk);
    load_btn = 1'b0; @(negedge clk);
    load_btn = 1'b1; @(negedge clk);
    load_btn = 1'b0; @(negedge clk);
    load_btn = 1'b1;
    wait_valid(20, 1'b0, 4'd0, n);
    check("load_latency", 32'(n), 6);
    repeat (3) @(negedge clk);
    load_btn = 1'b0;

    wait_valid(100, 1'b1, 4'd15, n);
    check("wait_pos15_found", 32'(n < 0), 0);
    wait_valid(100, 1'b1, 4'd5, n);
    check("wait_pos5_found", 32'(n < 0), 0);

    // Pause lands after the pos 6 bit, with one tick already counted.
    pause_btn = 1'b1;
    wait_paused(20, n);
    check("pause_latency", 32'(n), 6);
    check("pause_pos", 32'(pos), 6);
    check("pause_bit", 32'(bit_out), 32'(pat1[6]));
    pause_btn = 1'b0;
    held_ok = 1'b1;
    hold_bit = pat1[6];
    hold_pos = 4'd6;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bit_out !== hold_bit || pos !== hold_pos || paused !== 1'b1 || bit_valid !== 1'b0)
        held_ok = 1'b0;
    end
    check("pause_hold_100", 32'(held_ok), 1);

    // Resume: two ticks remain plus the wrap, after the 6-cycle button path.
    push_seq(pat1, 7, 13);
    pause_btn = 1'b1;
    toggle_en = 1'b1;
    wait_valid(20, 1'b0, 4'd0, n);
    check("resume_latency", 32'(n), 9);
    check("resume_paused_low", 32'(paused), 0);
    pause_btn = 1'b0;

    wait_valid(100, 1'b1, 4'd2, n);
    check("wait_pos2_found", 32'(n < 0), 0);
    pause_btn = 1'b1;
    wait_paused(20, n);
    check("pause2_latency", 32'(n), 6);
    check("pause2_pos", 32'(pos), 3);
    check("pause2_bit", 32'(bit_out), 32'(pat1[3]));
    pause_btn = 1'b0;
    repeat (10) @(negedge clk);

    // Load and pause in the same cycle while paused: load wins.
    toggle_en = 1'b0;
    pattern_in = pat2;
    push_seq(pat2, 0, 10);
    load_btn = 1'b1;
    pause_btn = 1'b1;
    wait_valid(20, 1'b0, 4'd0, n);
    check("load_pause_latency", 32'(n), 6);
    check("load_pause_paused", 32'(paused), 0);
    check("load_pause_pos", 32'(pos), 0);
    check("load_pause_bit", 32'(bit_out), 32'(pat2[0]));
    load_btn = 1'b0;
    pause_btn = 1'b0;

    // Reset in RUN at pos 9.
    wait_valid(100, 1'b1, 4'd9, n);
    check("wait_pos9_found", 32'(n < 0), 0);
    reset = 1'b1;
    @(negedge clk);
    check("midrun_reset_bit", 32'(bit_out), 0);
    check("midrun_reset_pos", 32'(pos), 0);
    check("midrun_reset_paused", 32'(paused), 0);
    check("midrun_reset_valid", 32'(bit_valid), 0);
    reset = 1'b0;
    wait_valid(30, 1'b0, 4'd0, n);
    check("no_valid_after_reset", 32'(n), 32'(-1));

    // Button held through reset release needs the full sync + debounce path.
    push_seq(pat2, 0, 3);
    load_btn = 1'b1;
    reset = 1'b1;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    wait_valid(20, 1'b0, 4'd0, n);
    check("held_through_reset_latency", 32'(n), 6);
    wait_valid(100, 1'b1, 4'd2, n);
    check("wait_final_pos2", 32'(n < 0), 0);
    load_btn = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("scoreboard_drained", 32'(q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
